// File: rtl/avmm_od_pio_pkg.sv
// rtl/avmm_od_pio_pkg.sv - register map and edge-type constants for avmm_od_pio
package avmm_od_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync.sv
// rtl/pio_sync.sv - multi-stage input synchroniser with configurable reset level
module pio_sync #(
  parameter int               WIDTH       = 2,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RESET_VALUE;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/avmm_od_pio.sv
// rtl/avmm_od_pio.sv - Avalon-MM GPIO with open-drain/push-pull drive, edge capture and irq
module avmm_od_pio
  import avmm_od_pio_pkg::*;
#(
  parameter int               WIDTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}},
  parameter bit               OPEN_DRAIN  = 1'b1,
  parameter int               EDGE_TYPE   = EDGE_ANY,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_q, dir_q, mask_q, cap_q, prev_q;
  logic [WIDTH-1:0] sync_in, rise, fall, edge_hit, wd, rd_w;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wd           = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Idle-high reset level keeps a pulled-up I2C bus from looking like an edge.
  pio_sync #(
    .WIDTH      (WIDTH),
    .STAGES     (SYNC_STAGES),
    .RESET_VALUE({WIDTH{1'b1}})
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (pad_in),
    .q      (sync_in)
  );

  assign rise = sync_in & ~prev_q;
  assign fall = ~sync_in & prev_q;

  always_comb begin
    edge_hit = rise | fall;
    if (EDGE_TYPE == EDGE_RISE) edge_hit = rise;
    else if (EDGE_TYPE == EDGE_FALL) edge_hit = fall;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      prev_q <= {WIDTH{1'b1}};
    end else begin
      prev_q <= sync_in;
      if (wr) begin
        case (address)
          ADDR_DATA:    data_q <= wd;
          ADDR_DIR:     dir_q  <= wd;
          ADDR_IRQMASK: mask_q <= wd;
          ADDR_OUTSET:  data_q <= data_q | wd;
          ADDR_OUTCLR:  data_q <= data_q & ~wd;
          default: ;
        endcase
      end
      // A fresh edge is OR-ed in after the clear so it is never lost.
      cap_q <= ((wr && address == ADDR_EDGECAP) ? (cap_q & ~wd) : cap_q) | edge_hit;
    end
  end

  always_comb begin
    rd_w = '0;
    case (address)
      ADDR_DATA:    rd_w = sync_in;
      ADDR_DIR:     rd_w = dir_q;
      ADDR_IRQMASK: rd_w = mask_q;
      ADDR_EDGECAP: rd_w = cap_q;
      ADDR_OUTSET:  rd_w = data_q;
      default:      rd_w = '0;
    endcase
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_w;
  end

  generate
    if (OPEN_DRAIN) begin : g_od
      assign pad_out = '0;
      assign pad_oe  = dir_q & ~data_q;
    end else begin : g_pp
      assign pad_out = data_q;
      assign pad_oe  = dir_q;
    end
  endgenerate

  assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_avmm_od_pio.sv
// tb/tb_avmm_od_pio.sv - self-checking bench for an open-drain and a push-pull avmm_od_pio
module tb_avmm_od_pio;

  localparam logic [31:0] WM [2] = '{32'h3, 32'hFF};
  localparam logic [31:0] RV [2] = '{32'h3, 32'h5A};
  localparam int          SS [2] = '{2, 3};
  localparam int          ET [2] = '{2, 0};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [31:0] rd_od, rd_pp;
  logic [1:0]  pad_in_od, pad_out_od, pad_oe_od;
  logic [7:0]  pad_in_pp, pad_out_pp, pad_oe_pp;
  logic        irq_od, irq_pp;

  int vectors = 0;
  int errs    = 0;

  logic [31:0] m_data [2], m_dir [2], m_mask [2], m_cap [2];
  logic [31:0] hist [2][6];

  always #10 clk = ~clk;

  avmm_od_pio #(
    .WIDTH(2), .RESET_VALUE(2'b11), .OPEN_DRAIN(1'b1), .EDGE_TYPE(2), .SYNC_STAGES(2)
  ) u_od (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_od),
    .pad_in(pad_in_od), .pad_out(pad_out_od), .pad_oe(pad_oe_od), .irq(irq_od)
  );

  avmm_od_pio #(
    .WIDTH(8), .RESET_VALUE(8'h5A), .OPEN_DRAIN(1'b0), .EDGE_TYPE(0), .SYNC_STAGES(3)
  ) u_pp (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_pp),
    .pad_in(pad_in_pp), .pad_out(pad_out_pp), .pad_oe(pad_oe_pp), .irq(irq_pp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_data[i] = RV[i];
      m_dir[i]  = '0;
      m_mask[i] = '0;
      m_cap[i]  = '0;
      for (int k = 0; k < 6; k++) hist[i][k] = WM[i];
    end
  endtask

  // hist[i][k] is the pad sample taken k edges ago; sync_in is SS-1 edges old.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] s, p, rise, fall, sel, pin, wd;
      s    = hist[i][SS[i]-1];
      p    = hist[i][SS[i]];
      rise = s & ~p;
      fall = ~s & p;
      sel  = (ET[i] == 0) ? rise : (ET[i] == 1) ? fall : (rise | fall);
      wd   = writedata & WM[i];
      pin  = (i == 0) ? {30'b0, pad_in_od} : {24'b0, pad_in_pp};
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data[i] = wd;
          3'd1: m_dir[i]  = wd;
          3'd2: m_mask[i] = wd;
          3'd3: m_cap[i]  = m_cap[i] & ~wd;
          3'd4: m_data[i] = m_data[i] | wd;
          3'd5: m_data[i] = m_data[i] & ~wd;
          default: ;
        endcase
      end
      m_cap[i] = m_cap[i] | (sel & WM[i]);
      for (int k = 5; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = pin & WM[i];
    end
  endtask

  function automatic logic [31:0] exp_rd(input int i, input int a);
    case (a)
      0: return hist[i][SS[i]-1];
      1: return m_dir[i];
      2: return m_mask[i];
      3: return m_cap[i];
      4: return m_data[i];
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_all();
    chk("od_pad_oe", {30'b0, pad_oe_od}, m_dir[0] & ~m_data[0] & WM[0]);
    chk("od_pad_out", {30'b0, pad_out_od}, 32'h0);
    chk("od_irq", {31'b0, irq_od}, {31'b0, |(m_cap[0] & m_mask[0])});
    chk("pp_pad_oe", {24'b0, pad_oe_pp}, m_dir[1]);
    chk("pp_pad_out", {24'b0, pad_out_pp}, m_data[1]);
    chk("pp_irq", {31'b0, irq_pp}, {31'b0, |(m_cap[1] & m_mask[1])});
    chipselect = 1'b1;
    write_n    = 1'b1;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("od_rd%0d", a), rd_od, exp_rd(0, a));
      chk($sformatf("pp_rd%0d", a), rd_pp, exp_rd(1, a));
    end
  endtask

  task automatic cycle(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rd(input logic [2:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    pad_in_od  = 2'b11;
    pad_in_pp  = 8'hFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_od_oe", {30'b0, pad_oe_od}, 32'h0);
    chk("rst_od_irq", {31'b0, irq_od}, 32'h0);
    rd(3'd4); chk("rst_outset_rd", rd_od, 32'h3);
    rd(3'd3); chk("rst_edgecap_rd", rd_od, 32'h0);
    reset_n = 1'b1;

    // Open-drain SCL pull-low and release
    cycle(1'b1, 1'b0, 3'd1, 32'h3);
    cycle(1'b1, 1'b0, 3'd5, 32'h1);
    chk("scl_low_oe", {30'b0, pad_oe_od}, 32'h1);
    cycle(1'b1, 1'b0, 3'd4, 32'h1);
    chk("scl_rel_oe", {30'b0, pad_oe_od}, 32'h0);

    // Input synchroniser latency on bit 1
    pad_in_od = 2'b01;
    cycle(1'b0, 1'b1, 3'd0, 32'h0);
    cycle(1'b0, 1'b1, 3'd0, 32'h0);
    rd(3'd0); chk("sync_data_n1", rd_od, 32'h1);
    rd(3'd3); chk("sync_cap_n1", rd_od, 32'h0);
    cycle(1'b0, 1'b1, 3'd0, 32'h0);
    rd(3'd3); chk("sync_cap_n2", rd_od, 32'h2);

    // Interrupt mask and clear
    cycle(1'b1, 1'b0, 3'd2, 32'h2);
    chk("irq_on", {31'b0, irq_od}, 32'h1);
    cycle(1'b1, 1'b0, 3'd3, 32'h2);
    chk("irq_cleared", {31'b0, irq_od}, 32'h0);
    cycle(1'b1, 1'b0, 3'd2, 32'h0);
    chk("irq_masked", {31'b0, irq_od}, 32'h0);

    // Edge arriving in the same cycle as its write-1-clear
    pad_in_od = 2'b00;
    cycle(1'b0, 1'b1, 3'd0, 32'h0);
    cycle(1'b0, 1'b1, 3'd0, 32'h0);
    cycle(1'b1, 1'b0, 3'd3, 32'h1);
    rd(3'd3); chk("collide_set_wins", rd_od & 32'h1, 32'h1);
    cycle(1'b1, 1'b0, 3'd3, 32'h1);
    rd(3'd3); chk("collide_then_clr", rd_od & 32'h1, 32'h0);

    // Push-pull data truncation and ignored address 6
    cycle(1'b1, 1'b0, 3'd0, 32'h1A5);
    chk("pp_out_a5", {24'b0, pad_out_pp}, 32'hA5);
    rd(3'd4); chk("pp_rd_hi_zero", rd_pp, 32'hA5);
    cycle(1'b1, 1'b0, 3'd6, $urandom);
    chk("pp_addr6_out", {24'b0, pad_out_pp}, 32'hA5);
    rd(3'd4); chk("pp_addr6_rd", rd_pp, 32'hA5);

    // Reset in the middle of a write cycle
    chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 32'hFF;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("midrst_pp_out", {24'b0, pad_out_pp}, 32'h5A);
    @(negedge clk);
    reset_n   = 1'b1;
    pad_in_od = 2'b11;
    pad_in_pp = 8'hFF;

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) == 0) pad_in_od = pad_in_od ^ 2'($urandom);
      if ($urandom_range(3) == 0) pad_in_pp = pad_in_pp ^ 8'($urandom);
      cycle(1'($urandom), 1'($urandom), 3'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
